bcd_rtc: RTL

- Parametrised BCD real-time clock and successor to the fixed 12-hour wall clock.
- Keeps hours, minutes and seconds in BCD and supports run-time 12h/24h display mode.
- Adds a tick prescaler, synchronous time load with validity checking, and second/day pulses.
- Sits between the system tick source and the display/host register block.

---
 rtl/rtc_pkg.sv | 50 +++++
 rtl/bcd_hour_conv.sv | 30 +++
 rtl/bcd_rtc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and BCD helpers for the bcd_rtc real-time clock.
package rtc_pkg;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_12 = 8'h12;

    typedef struct packed {
        logic       wrap;
        logic [7:0] val;
    } bcd_inc_t;

    function automatic bcd_inc_t bcd_inc8(input logic [7:0] v, input logic [7:0] max);
        bcd_inc_t r;
        r.wrap = 1'b0;
        if (v == max) begin
            r.val  = 8'h00;
            r.wrap = 1'b1;
        end else if (v[3:0] == 4'd9) begin
            r.val = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r.val = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic hour_valid(input logic [7:0] h, input logic mode24);
        return mode24 ? bcd_valid(h, BCD_23) : (bcd_valid(h, BCD_12) && (h != 8'h00));
    endfunction

    // Expects a valid 12h hour 01..12; PM hours get BCD +12.
    function automatic logic [7:0] h12_to_h24(input logic [7:0] h, input logic pm);
        logic [4:0] lo;
        logic [3:0] hi;
        lo = {1'b0, h[3:0]} + 5'd2;
        hi = h[7:4] + 4'd1;
        if (lo > 5'd9) begin
            lo = lo - 5'd10;
            hi = hi + 4'd1;
        end
        if (h == BCD_12) return pm ? BCD_12 : 8'h00;
        if (!pm) return h;
        return {hi, lo[3:0]};
    endfunction

endpackage

// File: rtl/bcd_hour_conv.sv
// Combinational 24h BCD hour to display hour (12h or 24h) and pm flag.
module bcd_hour_conv
    import rtc_pkg::*;
(
    input  logic [7:0] h24,
    input  logic       mode24,
    output logic [7:0] hh,
    output logic       pm
);

    logic [7:0] h12;

    // BCD subtract of 12 for afternoon hours 13..23.
    always_comb begin
        h12 = h24;
        if (h24 == 8'h00 || h24 == BCD_12) begin
            h12 = BCD_12;
        end else if (h24 > BCD_12) begin
            if (h24[3:0] >= 4'd2) begin
                h12 = {h24[7:4] - 4'd1, h24[3:0] - 4'd2};
            end else begin
                h12 = {h24[7:4] - 4'd2, h24[3:0] + 4'd8};
            end
        end
    end

    assign pm = (h24 >= BCD_12);
    assign hh = mode24 ? h24 : h12;

endmodule

// File: rtl/bcd_rtc.sv
// BCD real-time clock with tick prescaler, checked time load and second/day pulses.
// Optional alarm enabled by defining RTC_ALARM_EN.
module bcd_rtc
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [7:0]  RST_H24  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode24,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse,
`ifdef RTC_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm,
`endif
    output logic       load_err
);

    localparam int unsigned PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

    logic [7:0]    h24_q, h24_d, mm_q, mm_d, ss_q, ss_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d;
    logic          load_err_q, load_err_d;
    logic          load_ok, set_rej;
    logic [7:0]    load_h24;
    bcd_inc_t      s_inc, m_inc, h_inc;

    always_comb begin
        s_inc       = bcd_inc8(ss_q, BCD_59);
        m_inc       = bcd_inc8(mm_q, BCD_59);
        h_inc       = bcd_inc8(h24_q, BCD_23);
        load_h24    = mode24 ? load_hh : h12_to_h24(load_hh, load_pm);
        load_ok     = hour_valid(load_hh, mode24) && bcd_valid(load_mm, BCD_59)
                      && bcd_valid(load_ss, BCD_59);
        h24_d       = h24_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        pcnt_d      = pcnt_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = set_rej;
        // A load discards any tick arriving in the same cycle.
        if (load) begin
            if (load_ok) begin
                h24_d  = load_h24;
                mm_d   = load_mm;
                ss_d   = load_ss;
                pcnt_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (ena) begin
            if (pcnt_q == PCNT_MAX) begin
                pcnt_d      = '0;
                sec_pulse_d = 1'b1;
                ss_d        = s_inc.val;
                if (s_inc.wrap) begin
                    mm_d = m_inc.val;
                    if (m_inc.wrap) begin
                        h24_d       = h_inc.val;
                        day_pulse_d = h_inc.wrap;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h24_q       <= RST_H24;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            pcnt_q      <= '0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            h24_q       <= h24_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            pcnt_q      <= pcnt_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef RTC_ALARM_EN
    logic [7:0] al_h24_q, al_h24_d, al_mm_q, al_mm_d;
    logic       alarm_q, alarm_d, set_ok;

    always_comb begin
        set_ok   = hour_valid(alarm_hh, mode24) && bcd_valid(alarm_mm, BCD_59);
        set_rej  = alarm_set && !set_ok;
        al_h24_d = al_h24_q;
        al_mm_d  = al_mm_q;
        alarm_d  = alarm_q;
        if (alarm_set && set_ok) begin
            al_h24_d = mode24 ? alarm_hh : h12_to_h24(alarm_hh, alarm_pm);
            al_mm_d  = alarm_mm;
        end
        if (alarm_ack) alarm_d = 1'b0;
        // Match only on a second advance landing on hh:mm:00; a hit beats ack.
        if (sec_pulse_d && alarm_arm && h24_d == al_h24_q && mm_d == al_mm_q
            && ss_d == 8'h00) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_h24_q <= 8'h00;
            al_mm_q  <= 8'h00;
            alarm_q  <= 1'b0;
        end else begin
            al_h24_q <= al_h24_d;
            al_mm_q  <= al_mm_d;
            alarm_q  <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign set_rej = 1'b0;
`endif

    bcd_hour_conv u_hour_conv (
        .h24    (h24_q),
        .mode24 (mode24),
        .hh     (hh),
        .pm     (pm)
    );

    assign mm        = mm_q;
    assign ss        = ss_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign load_err  = load_err_q;

endmodule
